gpio_pin_bank: RTL

// Parametrised GPIO datapath core, next generation of the fixed 32-pin GPIO: Width pins, built-in input

---
 rtl/gpio_pkg.sv | 15 +
 rtl/gpio_pin_filter.sv | 55 +++++
 rtl/gpio_pin_bank.sv | 109 ++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared constants and types for the GPIO pin bank and its per-pin filter.
package gpio_pkg;

    localparam int unsigned DefWidth      = 32;
    localparam int unsigned DefSyncStages = 2;
    localparam int unsigned DefFiltCntW   = 4;

    typedef struct packed {
        logic rise;
        logic fall;
        logic hi;
        logic lo;
    } intr_ctrl_t;

endpackage

// File: rtl/gpio_pin_filter.sv
// One pin: multi-flop input synchroniser followed by a glitch filter that
// only accepts a new level after it has been stable for threshold+1 cycles.
module gpio_pin_filter
    import gpio_pkg::*;
#(
    parameter int unsigned SyncStages = DefSyncStages,
    parameter int unsigned FiltCntW   = DefFiltCntW
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                pin_i,
    input  logic [FiltCntW-1:0] filter_cycles_i,
    output logic                sync_o,
    output logic                filt_o
);

    logic [SyncStages-1:0] r_sync;
    logic                  r_filt;
    logic [FiltCntW-1:0]   r_cnt;
    logic                  w_sync;
    logic                  w_diff;
    logic                  w_sat;

    assign w_sync = r_sync[SyncStages-1];
    assign w_diff = w_sync != r_filt;
    assign w_sat  = &r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SyncStages-2:0], pin_i};
        end
    end

    // The compare is against the live threshold, so lowering it below an
    // in-flight count commits the new level on the very next edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_filt <= 1'b0;
            r_cnt  <= '0;
        end else if (!w_diff) begin
            r_cnt <= '0;
        end else if (r_cnt >= filter_cycles_i) begin
            r_filt <= w_sync;
            r_cnt  <= '0;
        end else if (!w_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign sync_o = w_sync;
    assign filt_o = r_filt;

endmodule

// File: rtl/gpio_pin_bank.sv
// GPIO datapath core: per-pin conditioning, masked output/OE registers,
// edge/level interrupt capture and aggregation.
module gpio_pin_bank
    import gpio_pkg::*;
#(
    parameter int unsigned Width      = DefWidth,
    parameter int unsigned SyncStages = DefSyncStages,
    parameter int unsigned FiltCntW   = DefFiltCntW
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [Width-1:0]    cio_gpio_i,
    output logic [Width-1:0]    cio_gpio_o,
    output logic [Width-1:0]    cio_gpio_en_o,
    input  logic                out_we_i,
    input  logic                out_tgl_i,
    input  logic [Width-1:0]    out_data_i,
    input  logic [Width-1:0]    out_mask_i,
    input  logic                oe_we_i,
    input  logic [Width-1:0]    oe_data_i,
    input  logic [Width-1:0]    oe_mask_i,
    input  logic [Width-1:0]    filter_en_i,
    input  logic [FiltCntW-1:0] filter_cycles_i,
    input  logic [Width-1:0]    ctrl_rise_i,
    input  logic [Width-1:0]    ctrl_fall_i,
    input  logic [Width-1:0]    ctrl_hi_i,
    input  logic [Width-1:0]    ctrl_lo_i,
    input  logic [Width-1:0]    intr_en_i,
    input  logic [Width-1:0]    intr_clr_i,
    input  logic [Width-1:0]    intr_test_i,
    output logic [Width-1:0]    data_in_o,
    output logic [Width-1:0]    intr_state_o,
    output logic [Width-1:0]    intr_o,
    output logic                irq_o
);

    logic [Width-1:0] r_out;
    logic [Width-1:0] r_oe;
    logic [Width-1:0] r_prev;
    logic [Width-1:0] r_intr_state;

    logic [Width-1:0] w_sync;
    logic [Width-1:0] w_filt;
    logic [Width-1:0] w_data_in;
    logic [Width-1:0] w_event;
    intr_ctrl_t [Width-1:0] w_ctrl;

    for (genvar gi = 0; gi < Width; gi++) begin : g_pin
        gpio_pin_filter #(
            .SyncStages(SyncStages),
            .FiltCntW  (FiltCntW)
        ) u_filter (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .pin_i          (cio_gpio_i[gi]),
            .filter_cycles_i(filter_cycles_i),
            .sync_o         (w_sync[gi]),
            .filt_o         (w_filt[gi])
        );

        assign w_data_in[gi]   = filter_en_i[gi] ? w_filt[gi] : w_sync[gi];
        assign w_ctrl[gi].rise = ctrl_rise_i[gi];
        assign w_ctrl[gi].fall = ctrl_fall_i[gi];
        assign w_ctrl[gi].hi   = ctrl_hi_i[gi];
        assign w_ctrl[gi].lo   = ctrl_lo_i[gi];

        assign w_event[gi] = (w_ctrl[gi].rise & ~r_prev[gi] &  w_data_in[gi])
                           | (w_ctrl[gi].fall &  r_prev[gi] & ~w_data_in[gi])
                           | (w_ctrl[gi].hi   &  w_data_in[gi])
                           | (w_ctrl[gi].lo   & ~w_data_in[gi]);
    end

    // A write and a toggle in the same cycle: the write wins outright.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out <= '0;
        end else if (out_we_i) begin
            r_out <= (out_data_i & out_mask_i) | (r_out & ~out_mask_i);
        end else if (out_tgl_i) begin
            r_out <= r_out ^ out_mask_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_oe <= '0;
        end else if (oe_we_i) begin
            r_oe <= (oe_data_i & oe_mask_i) | (r_oe & ~oe_mask_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_prev       <= '0;
            r_intr_state <= '0;
        end else begin
            r_prev       <= w_data_in;
            r_intr_state <= (r_intr_state & ~intr_clr_i) | w_event | intr_test_i;
        end
    end

    assign cio_gpio_o    = r_out;
    assign cio_gpio_en_o = r_oe;
    assign data_in_o     = w_data_in;
    assign intr_state_o  = r_intr_state;
    assign intr_o        = r_intr_state & intr_en_i;
    assign irq_o         = |intr_o;

endmodule
